// File: rtl/upe_negate_sched.sv
// upe_negate_sched
// Round-robin scheduler that shares one external upe_negate64u datapath
// between NREQ requesters and returns each result, tagged with the index
// of the requester that produced it, through a one-entry output register.
//
// Optional feature macro: UPE_NEGATE_SCHED_CHECK_EN
//   When defined, every fire compares neg_out against a local complement
//   of neg_in, and a mismatch sets the sticky rsp_err output.
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   req_valid  per-requester operand valid
//   req_data   operands; requester i occupies [64*i+63 : 64*i]
//   req_ready  one-hot grant, high only for the requester served this cycle
//   neg_in     operand driven to the shared negate unit
//   neg_out    combinational result from the shared negate unit
//   rsp_valid  output register holds a result
//   rsp_ready  consumer accepts the result
//   rsp_data   registered result
//   rsp_id     index of the requester that produced rsp_data
//   rsp_err    sticky self-check mismatch (only with UPE_NEGATE_SCHED_CHECK_EN)
//
// State table:
//   state   | meaning
//   S_EMPTY | output register holds nothing; a grant can always fire
//   S_FULL  | output register holds a result; a grant fires only on drain

module upe_negate_sched #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [NREQ-1:0]      req_valid,
    input  logic [64*NREQ-1:0]   req_data,
    output logic [NREQ-1:0]      req_ready,
    output logic [63:0]          neg_in,
    input  logic [63:0]          neg_out,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [63:0]          rsp_data,
    output logic [IDW-1:0]       rsp_id
`ifdef UPE_NEGATE_SCHED_CHECK_EN
    ,
    output logic                 rsp_err
`endif
);

    typedef enum logic {
        S_EMPTY = 1'b0,
        S_FULL  = 1'b1
    } state_t;

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] win_id;
    logic [IDW-1:0] ptr_nxt;
    logic           win_found;
    logic           slot_free;
    logic           fire;

    // ptr + k modulo NREQ; ptr is always < NREQ so one subtraction suffices.
    function automatic logic [IDW-1:0] wrap_add(input logic [IDW-1:0] base, input int k);
        int s;
        s = int'(base) + k;
        if (s >= NREQ) s = s - NREQ;
        return IDW'(s);
    endfunction

    // Scan from the farthest offset down to ptr itself so the last hit
    // (the one closest to ptr) wins. With no hit, win_id stays at ptr,
    // which also keeps neg_in on a real operand slice.
    always_comb begin
        win_found = 1'b0;
        win_id    = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (req_valid[wrap_add(ptr, k)]) begin
                win_found = 1'b1;
                win_id    = wrap_add(ptr, k);
            end
        end
    end

    assign ptr_nxt   = (int'(win_id) == NREQ - 1) ? '0 : win_id + IDW'(1);
    assign slot_free = (state == S_EMPTY) || rsp_ready;
    assign fire      = !rst && slot_free && win_found;
    assign req_ready = fire ? (NREQ'(1) << win_id) : '0;
    assign neg_in    = req_data[64*win_id +: 64];
    assign rsp_valid = (state == S_FULL);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_EMPTY;
            ptr      <= '0;
            rsp_data <= '0;
            rsp_id   <= '0;
        end else begin
            if (fire) begin
                // A fire while FULL also drains, so the slot stays FULL.
                state    <= S_FULL;
                rsp_data <= neg_out;
                rsp_id   <= win_id;
                ptr      <= ptr_nxt;
            end else if (state == S_FULL && rsp_ready) begin
                state <= S_EMPTY;
            end
        end
    end

`ifdef UPE_NEGATE_SCHED_CHECK_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            rsp_err <= 1'b0;
        end else if (fire && (neg_out != ~neg_in)) begin
            rsp_err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_upe_negate_sched.sv
// tb_upe_negate_sched
// Bench for upe_negate_sched. The shared negate unit is modelled here as
// a bitwise complement, with a corrupt switch used for the self-check case.

module tb_upe_negate_sched;
    localparam int NREQ = 4;
    localparam int IDW  = 2;

    logic                 clk = 1'b0;
    logic                 rst;
    logic [NREQ-1:0]      req_valid;
    logic [64*NREQ-1:0]   req_data;
    logic [NREQ-1:0]      req_ready;
    logic [63:0]          neg_in;
    logic [63:0]          neg_out;
    logic                 rsp_valid;
    logic                 rsp_ready;
    logic [63:0]          rsp_data;
    logic [IDW-1:0]       rsp_id;
`ifdef UPE_NEGATE_SCHED_CHECK_EN
    logic                 rsp_err;
`endif
    logic                 corrupt = 1'b0;

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the output register and round-robin pointer
    // must hold according to the scheduling rules.
    int              m_ptr  = 0;
    bit              m_full = 1'b0;
    logic [63:0]     m_data = '0;
    int              m_id   = 0;
    bit              m_err  = 1'b0;
    logic [NREQ-1:0] consumed = '0;
    int              ready_cnt [NREQ];

    always #5 clk = ~clk;

    assign neg_out = corrupt ? neg_in : ~neg_in;

    upe_negate_sched #(.NREQ(NREQ), .IDW(IDW)) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ready (req_ready),
        .neg_in    (neg_in),
        .neg_out   (neg_out),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_data  (rsp_data),
        .rsp_id    (rsp_id)
`ifdef UPE_NEGATE_SCHED_CHECK_EN
        ,
        .rsp_err   (rsp_err)
`endif
    );

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // First valid requester at or after p, walking upward with wrap.
    function automatic int winner(input logic [NREQ-1:0] v, input int p);
        for (int k = 0; k < NREQ; k++) begin
            if (v[(p + k) % NREQ]) return (p + k) % NREQ;
        end
        return -1;
    endfunction

    always @(posedge clk) begin : model
        int w;
        bit f;
        w = winner(req_valid, m_ptr);
        f = (rst === 1'b0) && (!m_full || rsp_ready) && (w >= 0);
        consumed = '0;
        if (rst) begin
            m_full = 1'b0;
            m_data = '0;
            m_id   = 0;
            m_ptr  = 0;
            m_err  = 1'b0;
        end else if (f) begin
            consumed[w] = 1'b1;
            m_data = corrupt ? req_data[64*w +: 64] : ~req_data[64*w +: 64];
            m_id   = w;
            m_full = 1'b1;
            m_ptr  = (w + 1) % NREQ;
            if (corrupt) m_err = 1'b1;
        end else if (m_full && rsp_ready) begin
            m_full = 1'b0;
        end
    end

    always @(negedge clk) begin : compare
        int w;
        int sel;
        logic [NREQ-1:0] er;
        w   = winner(req_valid, m_ptr);
        sel = (w >= 0) ? w : m_ptr;
        er  = ((rst === 1'b0) && (!m_full || rsp_ready) && (w >= 0)) ? (NREQ'(1) << w) : '0;
        chk("req_ready", req_ready, er);
        chk("neg_in", neg_in, req_data[64*sel +: 64]);
        chk("rsp_valid", rsp_valid, m_full);
        chk("rsp_data", rsp_data, m_data);
        chk("rsp_id", rsp_id, m_id);
`ifdef UPE_NEGATE_SCHED_CHECK_EN
        chk("rsp_err", rsp_err, m_err);
`endif
        for (int i = 0; i < NREQ; i++) if (req_ready[i]) ready_cnt[i]++;
    end

    initial begin
        int exp_g [5];
        int c0;
        int c2;
        exp_g = '{0, 1, 2, 3, 0};
        for (int i = 0; i < NREQ; i++) ready_cnt[i] = 0;
        rst       = 1'b1;
        req_valid = '0;
        req_data  = '0;
        rsp_ready = 1'b1;

        // Reset held two edges, then a single request from requester 0.
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        req_valid[0]    = 1'b1;
        req_data[63:0]  = 64'hA32AEACECB2AEACE;
        @(negedge clk);
        chk("t1_ready", req_ready, 4'b0001);
        @(posedge clk);
        #1 req_valid = '0;
        @(negedge clk);
        chk("t1_valid", rsp_valid, 1);
        chk("t1_data", rsp_data, 64'h5CD5153134D51531);
        chk("t1_id", rsp_id, 0);
        chk("t1_noregrant", req_ready, 0);
        repeat (2) @(posedge clk);
        #1 chk("t1_once", ready_cnt[0], 1);

        // Round robin with all four valid, data 0..3.
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid = '1;
        for (int i = 0; i < NREQ; i++) req_data[64*i +: 64] = 64'(i);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("rr_grant", req_ready, NREQ'(1) << exp_g[k]);
            if (k > 0) chk("rr_data", rsp_data, ~64'(exp_g[k-1]));
        end

        // Backpressure: the last grant (requester 0) sits in the slot.
        @(posedge clk);
        #1 rsp_ready = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            chk("bp_ready", req_ready, 0);
            chk("bp_valid", rsp_valid, 1);
            chk("bp_data", rsp_data, 64'hFFFFFFFFFFFFFFFF);
            chk("bp_id", rsp_id, 0);
        end
        @(posedge clk);
        #1 rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_release", req_ready, 4'b0010);

        // Sparse requesters 1 and 3 from a fresh pointer.
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("rst_no_grant", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        c0 = ready_cnt[0];
        c2 = ready_cnt[2];
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            chk("sp_grant", req_ready, (k % 2 == 1) ? 4'b1000 : 4'b0010);
        end
        @(posedge clk);
        #1 chk("sp_skip0", ready_cnt[0], c0);
        chk("sp_skip2", ready_cnt[2], c2);

        // Reset while FULL with rsp_id = 2.
        req_valid = '0;
        repeat (2) @(posedge clk);
        #1 req_valid = 4'b0100;
        req_data[128 +: 64] = {$urandom, $urandom};
        @(posedge clk);
        #1 req_valid = '0;
        rsp_ready = 1'b0;
        @(negedge clk);
        chk("mr_full", rsp_valid, 1);
        chk("mr_id2", rsp_id, 2);
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = 4'b1010;
        @(negedge clk);
        chk("mr_rst_ready", req_ready, 0);
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mr_valid", rsp_valid, 0);
        chk("mr_data", rsp_data, 0);
        chk("mr_id", rsp_id, 0);
        chk("mr_first", req_ready, 4'b0010);

        // Randomized traffic; requesters hold until granted.
        for (int c = 0; c < 3000; c++) begin
            @(posedge clk);
            #1;
            for (int i = 0; i < NREQ; i++) begin
                if (consumed[i]) begin
                    if ($urandom_range(1, 0) == 0) req_valid[i] = 1'b0;
                    else req_data[64*i +: 64] = {$urandom, $urandom};
                end else if (!req_valid[i] && $urandom_range(2, 0) == 0) begin
                    req_valid[i] = 1'b1;
                    req_data[64*i +: 64] = {$urandom, $urandom};
                end
            end
            rsp_ready = ($urandom_range(3, 0) != 0);
            rst = ($urandom_range(199, 0) == 0);
        end

`ifdef UPE_NEGATE_SCHED_CHECK_EN
        // Corrupted negate result on one fire.
        @(posedge clk);
        #1 rst = 1'b1;
        req_valid = '0;
        rsp_ready = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        req_valid[0] = 1'b1;
        req_data[63:0] = {$urandom, $urandom};
        corrupt = 1'b1;
        @(negedge clk);
        chk("err_before", rsp_err, 0);
        @(posedge clk);
        #1 corrupt = 1'b0;
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("err_sticky", rsp_err, 1);
        end
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("err_clear", rsp_err, 0);
`endif

        @(posedge clk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
